// File: rtl/idu_stage.sv
// RV64I/M decode stage: regfile with write-first bypass, per-register RAW scoreboard; optional IDU_SCB_CHECK_EN adds scb_err.
// Latency: one cycle from accept to out_*; 1 instruction/cycle without hazards.
// Backpressure: in_ready drops on !out_ready with a held output, on a RAW/saturation hazard, or on flush.
module idu_stage #(
  parameter int XLEN  = 64,
  parameter int SCB_W = 2,
  parameter int PC_W  = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [PC_W-1:0] in_pc,
  input  logic            flush,
  input  logic            rdwen,
  input  logic [4:0]      rdin,
  input  logic [XLEN-1:0] rddata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1data,
  output logic [XLEN-1:0] out_rs2data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rd,
  output logic            out_rd_wen,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic            out_word,
`ifdef IDU_SCB_CHECK_EN
  output logic            scb_err,
`endif
  output logic            out_illegal
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] rs1data;
    logic [XLEN-1:0] rs2data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic            rd_wen;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic            word;
    logic            illegal;
  } dec_t;

  localparam logic [SCB_W-1:0] CNT_MAX = {SCB_W{1'b1}};

  logic [XLEN-1:0]  rf [32];
  logic [SCB_W-1:0] cnt [32];
  logic [SCB_W-1:0] cnt_nxt [32];
  dec_t             dec, q;
  logic             hazard, accept;
  logic             is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st;
  logic             is_opi, is_op, is_opi32, is_op32, is_misc, is_sys;
  logic             use_rs1, use_rs2, wen_raw;
  logic [4:0]       rs1, rs2, rd;
  logic [31:0]      imm32;
  logic [SCB_W:0]   t, d, r;
`ifdef IDU_SCB_CHECK_EN
  logic             scb_evt;
`endif

  assign rs1 = in_inst[19:15];
  assign rs2 = in_inst[24:20];
  assign rd  = in_inst[11:7];

  always_comb begin
    is_lui   = in_inst[6:0] == 7'b0110111;
    is_auipc = in_inst[6:0] == 7'b0010111;
    is_jal   = in_inst[6:0] == 7'b1101111;
    is_jalr  = in_inst[6:0] == 7'b1100111;
    is_br    = in_inst[6:0] == 7'b1100011;
    is_ld    = in_inst[6:0] == 7'b0000011;
    is_st    = in_inst[6:0] == 7'b0100011;
    is_opi   = in_inst[6:0] == 7'b0010011;
    is_op    = in_inst[6:0] == 7'b0110011;
    is_opi32 = in_inst[6:0] == 7'b0011011;
    is_op32  = in_inst[6:0] == 7'b0111011;
    is_misc  = in_inst[6:0] == 7'b0001111;
    is_sys   = in_inst[6:0] == 7'b1110011;

    use_rs1 = !(is_lui || is_auipc || is_jal || (is_sys && in_inst[14]));
    use_rs2 = is_br || is_st || is_op || is_op32;

    imm32 = '0;
    if (is_lui || is_auipc)
      imm32 = {in_inst[31:12], 12'b0};
    else if (is_jal)
      imm32 = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
    else if (is_br)
      imm32 = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    else if (is_st)
      imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    else if (is_jalr || is_ld || is_opi || is_opi32 || is_misc || is_sys)
      imm32 = {{20{in_inst[31]}}, in_inst[31:20]};

    dec         = '0;
    dec.pc      = in_pc;
    dec.opcode  = in_inst[6:0];
    dec.funct3  = in_inst[14:12];
    dec.funct7  = in_inst[31:25];
    dec.rd      = rd;
    dec.imm     = XLEN'($signed(imm32));
    dec.word    = (is_opi32 || is_op32) && (XLEN == 64);
    dec.illegal = !(is_lui || is_auipc || is_jal || is_jalr || is_br || is_ld || is_st ||
                    is_opi || is_op || is_misc || is_sys || dec.word);
    wen_raw     = is_lui || is_auipc || is_jal || is_jalr || is_ld || is_opi || is_op ||
                  dec.word || (is_sys && in_inst[14:12] != 3'b000);
    dec.rd_wen  = wen_raw && (rd != 5'd0);
    // Same-cycle write-back wins over the array (write-first bypass)
    dec.rs1data = (!use_rs1 || rs1 == 5'd0) ? '0 : (rdwen && rdin == rs1) ? rddata : rf[rs1];
    dec.rs2data = (!use_rs2 || rs2 == 5'd0) ? '0 : (rdwen && rdin == rs2) ? rddata : rf[rs2];
  end

  // A write-back retiring the last pending write releases the reader in the same cycle
  always_comb begin
    hazard = 1'b0;
    if (use_rs1 && rs1 != 5'd0 && cnt[rs1] != '0 &&
        !(rdwen && rdin == rs1 && cnt[rs1] == SCB_W'(1)))
      hazard = 1'b1;
    if (use_rs2 && rs2 != 5'd0 && cnt[rs2] != '0 &&
        !(rdwen && rdin == rs2 && cnt[rs2] == SCB_W'(1)))
      hazard = 1'b1;
    if (dec.rd_wen && cnt[rd] == CNT_MAX && !(rdwen && rdin == rd))
      hazard = 1'b1;
  end

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    for (int i = 0; i < 32; i++) cnt_nxt[i] = '0;
    t = '0;
    d = '0;
    r = '0;
`ifdef IDU_SCB_CHECK_EN
    scb_evt = 1'b0;
`endif
    for (int i = 1; i < 32; i++) begin
      t = {1'b0, cnt[i]} + (SCB_W+1)'(accept && dec.rd_wen && dec.rd == 5'(i));
      d = (SCB_W+1)'(rdwen && rdin == 5'(i) && cnt[i] != '0) +
          (SCB_W+1)'(flush && out_valid && q.rd_wen && q.rd == 5'(i));
      r = t - d;
      if (t < d)
        cnt_nxt[i] = '0;
      else if (r[SCB_W])
        cnt_nxt[i] = CNT_MAX;
      else
        cnt_nxt[i] = r[SCB_W-1:0];
`ifdef IDU_SCB_CHECK_EN
      if ((rdwen && rdin == 5'(i) && cnt[i] == '0) || (t >= d && r[SCB_W]))
        scb_evt = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 32; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && rdwen && rdin != 5'd0)
      rf[rdin] <= rddata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      q         <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      q         <= dec;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef IDU_SCB_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      scb_err <= 1'b0;
    end else if (scb_evt) begin
      scb_err <= 1'b1;
      $error("idu_stage: scoreboard underflow/overflow");
    end
  end
`endif

  assign out_pc      = q.pc;
  assign out_rs1data = q.rs1data;
  assign out_rs2data = q.rs2data;
  assign out_imm     = q.imm;
  assign out_rd      = q.rd;
  assign out_rd_wen  = q.rd_wen;
  assign out_opcode  = q.opcode;
  assign out_funct3  = q.funct3;
  assign out_funct7  = q.funct7;
  assign out_word    = q.word;
  assign out_illegal = q.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Bench for idu_stage: expected decodes queued at accept, compared when EX takes (or flush kills) the output.
module tb_idu_stage;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, rdwen, out_valid, out_ready;
  logic [31:0] in_inst;
  logic [63:0] in_pc, rddata, out_pc, out_rs1data, out_rs2data, out_imm;
  logic [4:0]  rdin, out_rd;
  logic        out_rd_wen, out_word, out_illegal;
  logic [6:0]  out_opcode, out_funct7;
  logic [2:0]  out_funct3;
`ifdef IDU_SCB_CHECK_EN
  logic        scb_err, scb_err32;
`endif

  // Second instance at XLEN=32 for W-type illegality
  logic        v32, r32, ov32, rdwen32, rw32, w32, ill32;
  logic [31:0] i32, rd32dat, o32_rs1, o32_rs2, o32_imm;
  logic [63:0] pc32, o32_pc;
  logic [4:0]  rdin32, o32_rd;
  logic [6:0]  o32_op, o32_f7;
  logic [2:0]  o32_f3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] pc, rs1, rs2, imm;
    logic [4:0]  rd;
    logic        wen, word, ill;
    logic [6:0]  op, f7;
    logic [2:0]  f3;
  } exp_t;
  exp_t exp_q[$];

  idu_stage #(.XLEN(64), .SCB_W(2), .PC_W(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .flush(flush), .rdwen(rdwen), .rdin(rdin), .rddata(rddata),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1data(out_rs1data), .out_rs2data(out_rs2data), .out_imm(out_imm),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_opcode(out_opcode),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_word(out_word),
`ifdef IDU_SCB_CHECK_EN
    .scb_err(scb_err),
`endif
    .out_illegal(out_illegal));

  idu_stage #(.XLEN(32), .SCB_W(2), .PC_W(64)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(r32), .in_inst(i32),
    .in_pc(pc32), .flush(1'b0), .rdwen(rdwen32), .rdin(rdin32), .rddata(rd32dat),
    .out_valid(ov32), .out_ready(1'b1), .out_pc(o32_pc),
    .out_rs1data(o32_rs1), .out_rs2data(o32_rs2), .out_imm(o32_imm),
    .out_rd(o32_rd), .out_rd_wen(rw32), .out_opcode(o32_op),
    .out_funct3(o32_f3), .out_funct7(o32_f7), .out_word(w32),
`ifdef IDU_SCB_CHECK_EN
    .scb_err(scb_err32),
`endif
    .out_illegal(ill32));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [63:0] pc, rs1, rs2, imm, input logic wen,
                              input logic word, input logic ill, input logic [31:0] inst);
    exp_t e;
    e.pc = pc; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm; e.wen = wen; e.word = word; e.ill = ill;
    e.rd = inst[11:7]; e.op = inst[6:0]; e.f3 = inst[14:12]; e.f7 = inst[31:25];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wb(input logic [4:0] idx, input logic [63:0] data);
    rdwen = 1'b1; rdin = idx; rddata = data;
    tick();
    rdwen = 1'b0;
  endtask

  // Presents one instruction until accepted (bounded); n = stall cycles seen
  task automatic send(input logic [31:0] inst, input exp_t e, output int n);
    n = 0;
    in_valid = 1'b1; in_inst = inst; in_pc = e.pc;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 64'(in_ready), 64'd1);
    if (in_ready) exp_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && (out_ready || flush)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 64'(out_valid), 64'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pc", out_pc, e.pc);
        check("rs1data", out_rs1data, e.rs1);
        check("rs2data", out_rs2data, e.rs2);
        check("imm", out_imm, e.imm);
        check("rd", 64'(out_rd), 64'(e.rd));
        check("rd_wen", 64'(out_rd_wen), 64'(e.wen));
        check("opcode", 64'(out_opcode), 64'(e.op));
        check("funct3", 64'(out_funct3), 64'(e.f3));
        check("funct7", 64'(out_funct7), 64'(e.f7));
        check("word", 64'(out_word), 64'(e.word));
        check("illegal", 64'(out_illegal), 64'(e.ill));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; in_inst = '0; in_pc = '0; flush = 1'b0;
    rdwen = 1'b0; rdin = '0; rddata = '0; out_ready = 1'b0;
    v32 = 1'b0; i32 = '0; pc32 = '0; rdwen32 = 1'b0; rdin32 = '0; rd32dat = '0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rs1data", out_rs1data, 64'd0);
    check("rst_imm", out_imm, 64'd0);
    check("rst_pc", out_pc, 64'd0);
    check("rst_rd_wen", 64'(out_rd_wen), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    wb(5'd1, 64'h11); wb(5'd2, 64'h22); wb(5'd3, 64'h33);
    wb(5'd5, 64'h1234); wb(5'd9, 64'h99); wb(5'd17, 64'h17);

    // ADDI x6,x5,-1
    out_ready = 1'b1;
    send(32'hFFF28313, mk(64'h100, 64'h1234, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 32'hFFF28313), n);
    @(negedge clk);
    check("s1_out_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;

    // ADD x7,x1,x2 then SUB x8,x7,x3 stalls until x7 write-back
    send(32'h002083B3, mk(64'h200, 64'h11, 64'h22, 64'h0, 1, 0, 0, 32'h002083B3), n);
    in_valid = 1'b1; in_inst = 32'h40338433; in_pc = 64'h204;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("raw_stall", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    rdwen = 1'b1; rdin = 5'd7; rddata = 64'hAAAA;
    @(negedge clk);
    check("raw_release", 64'(in_ready), 64'd1);
    if (in_ready) exp_q.push_back(mk(64'h204, 64'hAAAA, 64'h33, 64'h0, 1, 0, 0, 32'h40338433));
    @(posedge clk); #1;
    in_valid = 1'b0; rdwen = 1'b0;

    // Back-to-back mix of immediate formats
    send(32'hFE20AC23, mk(64'h220, 64'h11, 64'h22, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 32'hFE20AC23), n);
    check("b2b_sw", 64'(n), 64'd0);
    send(32'h00208863, mk(64'h224, 64'h11, 64'h22, 64'd16, 0, 0, 0, 32'h00208863), n);
    check("b2b_beq", 64'(n), 64'd0);
    send(32'hFFDFF06F, mk(64'h228, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 0, 0, 32'hFFDFF06F), n);
    check("b2b_jal", 64'(n), 64'd0);
    send(32'h12345617, mk(64'h22C, 64'h0, 64'h0, 64'h12345000, 1, 0, 0, 32'h12345617), n);
    check("b2b_auipc", 64'(n), 64'd0);
    send(32'h0010069B, mk(64'h230, 64'h0, 64'h0, 64'h1, 1, 1, 0, 32'h0010069B), n);
    check("b2b_addiw", 64'(n), 64'd0);
    send(32'h0000007F, mk(64'h234, 64'h0, 64'h0, 64'h0, 0, 0, 1, 32'h0000007F), n);
    check("b2b_illegal", 64'(n), 64'd0);
    tick();

    // Output held under backpressure
    out_ready = 1'b0;
    send(32'h00500713, mk(64'h300, 64'h0, 64'h0, 64'd5, 1, 0, 0, 32'h00500713), n);
    in_inst = 32'h00700793; in_pc = 64'h304;
    for (int i = 0; i < 4; i++) begin
      in_valid = i[0];
      @(negedge clk);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_pc", out_pc, 64'h300);
      check("hold_imm", out_imm, 64'd5);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(32'h00700793, mk(64'h304, 64'h0, 64'h0, 64'd7, 1, 0, 0, 32'h00700793), n);
    check("release_wait", 64'(n), 64'd0);
    @(negedge clk);
    check("release_pc", out_pc, 64'h304);
    @(posedge clk); #1;

    // Flush of held LUI x9 clears its pending count
    out_ready = 1'b0;
    send(32'h800004B7, mk(64'h400, 64'h0, 64'h0, 64'hFFFF_FFFF_8000_0000, 1, 0, 0, 32'h800004B7), n);
    tick();
    flush = 1'b1;
    @(negedge clk);
    check("flush_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h00048813, mk(64'h404, 64'h99, 64'h0, 64'h0, 1, 0, 0, 32'h00048813), n);
    check("flush_no_stall", 64'(n), 64'd0);

    // Saturation: three pending writers to x10, fourth waits for a write-back
    for (int k = 1; k <= 3; k++) begin
      logic [31:0] ins;
      ins = 32'h00000513 | (32'(k) << 20);
      send(ins, mk(64'h500 + 64'(4 * k), 64'h0, 64'h0, 64'(k), 1, 0, 0, ins), n);
      check("sat_fill", 64'(n), 64'd0);
    end
    in_valid = 1'b1; in_inst = 32'h00400513; in_pc = 64'h510;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("sat_stall", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
    end
    rdwen = 1'b1; rdin = 5'd10; rddata = 64'h10;
    @(negedge clk);
    check("sat_release", 64'(in_ready), 64'd1);
    if (in_ready) exp_q.push_back(mk(64'h510, 64'h0, 64'h0, 64'd4, 1, 0, 0, 32'h00400513));
    @(posedge clk); #1;
    in_valid = 1'b0; rdwen = 1'b0;
    tick();

    // Reset drops a held writer and its pending count
    out_ready = 1'b0;
    send(32'h00100893, mk(64'h600, 64'h0, 64'h0, 64'd1, 1, 0, 0, 32'h00100893), n);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_imm", out_imm, 64'd0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(32'h00088913, mk(64'h604, 64'h17, 64'h0, 64'h0, 1, 0, 0, 32'h00088913), n);
    check("mid_rst_no_stall", 64'(n), 64'd0);

`ifdef IDU_SCB_CHECK_EN
    check("scb_err_clear", 64'(scb_err), 64'd0);
    wb(5'd11, 64'h5);
    @(negedge clk);
    check("scb_err_set", 64'(scb_err), 64'd1);
    @(posedge clk); #1;
`endif

    // ADDIW at XLEN=32
    v32 = 1'b1; i32 = 32'h0010009B; pc32 = 64'h700;
    tick();
    v32 = 1'b0;
    @(negedge clk);
    check("x32_valid", 64'(ov32), 64'd1);
    check("x32_illegal", 64'(ill32), 64'd1);
    check("x32_word", 64'(w32), 64'd0);
    @(posedge clk); #1;

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
